// File: rtl/sw_conditioner_if.sv
// Switch conditioner bus: raw pins and clear mask in, debounced level,
// edge pulses, sticky change flags and the debug tick out.
interface sw_conditioner_if #(
  parameter int WIDTH = 16
);
  logic [WIDTH-1:0] sw_raw;
  logic [WIDTH-1:0] chg_clr;
  logic [WIDTH-1:0] sw_out;
  logic [WIDTH-1:0] sw_rise;
  logic [WIDTH-1:0] sw_fall;
  logic [WIDTH-1:0] sw_changed;
  logic             tick;

  // Board/cpu side: drives the pins and the clear mask, observes the results.
  modport master (
    output sw_raw, chg_clr,
    input  sw_out, sw_rise, sw_fall, sw_changed, tick
  );

  // Conditioner side.
  modport slave (
    input  sw_raw, chg_clr,
    output sw_out, sw_rise, sw_fall, sw_changed, tick
  );
endinterface

// File: rtl/sw_conditioner.sv
// Slide-switch conditioner: per-bit 2-flop synchroniser, tick-based debounce
// that accepts a new level only after STABLE_TICKS mismatching ticks,
// registered rise/fall pulses and write-1-to-clear sticky change flags.
module sw_conditioner #(
  parameter int WIDTH        = 16,
  parameter int TICK_DIV     = 100000,
  parameter int STABLE_TICKS = 10
) (
  input  logic              clk,
  input  logic              rst,
  sw_conditioner_if.slave   bus
);

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int CW = (STABLE_TICKS > 1) ? $clog2(STABLE_TICKS) : 1;
  localparam logic [PW-1:0] LAST_P = PW'(TICK_DIV - 1);
  localparam logic [CW-1:0] LAST_C = CW'(STABLE_TICKS - 1);

  typedef enum logic {STABLE, PENDING} deb_state_e;

  logic [WIDTH-1:0] s1;
  logic [WIDTH-1:0] s2;
  logic [PW-1:0]    presc;
  logic [PW-1:0]    presc_nx;
  logic             tick_r;
  logic [WIDTH-1:0] sw_out_r;
  logic [WIDTH-1:0] out_nx;
  logic [WIDTH-1:0] flip;
  logic [WIDTH-1:0] rise_r;
  logic [WIDTH-1:0] fall_r;
  logic [WIDTH-1:0] changed_r;
  logic [CW-1:0]    cnt    [WIDTH];
  logic [CW-1:0]    cnt_nx [WIDTH];
  deb_state_e       state  [WIDTH];

  // Prescaler wrap: count 0..TICK_DIV-1 and restart.
  always_comb begin
    presc_nx = presc + 1'b1;
    if (presc == LAST_P) presc_nx = '0;
  end

  // Synchroniser stages and prescaler; tick is registered so it reads 0 in reset
  // and is high exactly while presc sits at its last value.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1     <= '0;
      s2     <= '0;
      presc  <= '0;
      tick_r <= 1'b0;
    end else begin
      s1     <= bus.sw_raw;
      s2     <= s1;
      presc  <= presc_nx;
      tick_r <= (presc_nx == LAST_P);
    end
  end

  // Per-bit debounce next state: a bit is PENDING whenever the synchronised pin
  // disagrees with the accepted level; agreement at any time zeroes its counter.
  always_comb begin
    out_nx = sw_out_r;
    flip   = '0;
    for (int n = 0; n < WIDTH; n++) begin
      cnt_nx[n] = cnt[n];
      state[n]  = (s2[n] != sw_out_r[n]) ? PENDING : STABLE;
      case (state[n])
        STABLE: cnt_nx[n] = '0;
        PENDING: begin
          if (tick_r) begin
            if (cnt[n] == LAST_C) begin
              out_nx[n] = s2[n];
              cnt_nx[n] = '0;
              flip[n]   = 1'b1;
            end else begin
              cnt_nx[n] = cnt[n] + 1'b1;
            end
          end
        end
        default: cnt_nx[n] = '0;
      endcase
    end
  end

  // Debounce state register: accepted level and per-bit stability counters.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sw_out_r <= '0;
      for (int n = 0; n < WIDTH; n++) cnt[n] <= '0;
    end else begin
      sw_out_r <= out_nx;
      for (int n = 0; n < WIDTH; n++) cnt[n] <= cnt_nx[n];
    end
  end

  // Edge pulses and sticky flags update on the same edge as the accepted level;
  // a flip in the same cycle as a clear keeps the flag set.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rise_r    <= '0;
      fall_r    <= '0;
      changed_r <= '0;
    end else begin
      rise_r    <= flip & out_nx;
      fall_r    <= flip & ~out_nx;
      changed_r <= (changed_r & ~bus.chg_clr) | flip;
    end
  end

  assign bus.sw_out     = sw_out_r;
  assign bus.sw_rise    = rise_r;
  assign bus.sw_fall    = fall_r;
  assign bus.sw_changed = changed_r;
  assign bus.tick       = tick_r;

endmodule

// File: tb/tb_sw_conditioner.sv
// Bench for sw_conditioner: dut_a runs TICK_DIV=1/STABLE_TICKS=3 through a
// vector table plus reset and bounce sequences; dut_b runs TICK_DIV=4/STABLE_TICKS=2.
module tb_sw_conditioner;

  typedef struct {
    logic [15:0] raw;
    logic [15:0] clr;
    logic [15:0] out;
    logic [15:0] rise;
    logic [15:0] fall;
    logic [15:0] chg;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   n_cmp = 0;
  int   n_err = 0;
  vec_t tbl[$];

  always #5 clk = ~clk;

  sw_conditioner_if #(.WIDTH(16)) ifa ();
  sw_conditioner_if #(.WIDTH(16)) ifb ();

  sw_conditioner #(.WIDTH(16), .TICK_DIV(1), .STABLE_TICKS(3)) dut_a (
    .clk(clk), .rst(rst), .bus(ifa)
  );
  sw_conditioner #(.WIDTH(16), .TICK_DIV(4), .STABLE_TICKS(2)) dut_b (
    .clk(clk), .rst(rst), .bus(ifb)
  );

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic check_rng(input string name, input int act, input int lo, input int hi);
    n_cmp++;
    if (act < lo || act > hi) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d..%0d", name, act, lo, hi);
    end
  endtask

  task automatic add(input logic [15:0] raw, input logic [15:0] clr, input logic [15:0] out,
                     input logic [15:0] rise, input logic [15:0] fall, input logic [15:0] chg,
                     input int rep);
    vec_t v;
    v.raw = raw; v.clr = clr; v.out = out; v.rise = rise; v.fall = fall; v.chg = chg;
    for (int i = 0; i < rep; i++) tbl.push_back(v);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [15:0] lvl_o, lvl_t, noise, rise_acc, fall_acc, bad;
    int k, first, ticks, cnt, rises;
    logic tb_tick;

    ifa.sw_raw = '0; ifa.chg_clr = '0;
    ifb.sw_raw = '0; ifb.chg_clr = '0;

    // Vector table for dut_a; row i applies raw/clr before edge Ei, checks after it.
    add(16'h0001, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 4);
    add(16'h0001, 16'h0000, 16'h0001, 16'h0001, 16'h0000, 16'h0001, 1);
    add(16'h0001, 16'h0000, 16'h0001, 16'h0000, 16'h0000, 16'h0001, 1);
    add(16'h0009, 16'h0000, 16'h0001, 16'h0000, 16'h0000, 16'h0001, 2);
    add(16'h0001, 16'h0000, 16'h0001, 16'h0000, 16'h0000, 16'h0001, 4);
    add(16'h0000, 16'h0000, 16'h0001, 16'h0000, 16'h0000, 16'h0001, 4);
    add(16'h0000, 16'h0001, 16'h0000, 16'h0000, 16'h0001, 16'h0001, 1);
    add(16'h0000, 16'h0001, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 1);
    add(16'h0000, 16'h0002, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 1);
    add(16'h8100, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 4);
    add(16'h8100, 16'h0000, 16'h8100, 16'h8100, 16'h0000, 16'h8100, 1);
    add(16'h8100, 16'h0000, 16'h8100, 16'h0000, 16'h0000, 16'h8100, 1);
    add(16'h8100, 16'h8000, 16'h8100, 16'h0000, 16'h0000, 16'h0100, 1);
    add(16'h8100, 16'h0000, 16'h8100, 16'h0000, 16'h0000, 16'h0100, 1);

    // Reset state
    repeat (3) step();
    check("rst_out_a", ifa.sw_out, 16'h0);
    check("rst_chg_a", ifa.sw_changed, 16'h0);
    check("rst_tick_a", {15'h0, ifa.tick}, 16'h0);
    check("rst_out_b", ifb.sw_out, 16'h0);
    check("rst_tick_b", {15'h0, ifb.tick}, 16'h0);
    rst = 1'b1;

    foreach (tbl[i]) begin
      ifa.sw_raw  = tbl[i].raw;
      ifa.chg_clr = tbl[i].clr;
      step();
      check($sformatf("v%0d_out", i),  ifa.sw_out,     tbl[i].out);
      check($sformatf("v%0d_rise", i), ifa.sw_rise,    tbl[i].rise);
      check($sformatf("v%0d_fall", i), ifa.sw_fall,    tbl[i].fall);
      check($sformatf("v%0d_chg", i),  ifa.sw_changed, tbl[i].chg);
    end
    ifa.chg_clr = '0;

    // dut_b: A5A5 held, accepted on the second tick after s2 sees it
    ifb.sw_raw = 16'hA5A5;
    k = -1; ticks = 0; first = -1;
    while (k < 20 && first < 0) begin
      tb_tick = ifb.tick;
      step();
      k++;
      if (k >= 2 && tb_tick) ticks++;
      if (ifb.sw_out == 16'hA5A5) first = k;
      else check("t3_early_rise", ifb.sw_rise, 16'h0);
    end
    check_rng("t3_latency", first, 6, 9);
    check_rng("t3_ticks", ticks, 2, 2);
    check("t3_rise", ifb.sw_rise, 16'hA5A5);
    check("t3_chg", ifb.sw_changed, 16'hA5A5);
    step();
    check("t3_rise_off", ifb.sw_rise, 16'h0);
    check("t3_out_hold", ifb.sw_out, 16'hA5A5);

    // dut_b: tick period
    cnt = 0;
    while (!ifb.tick && cnt < 8) begin step(); cnt++; end
    check_rng("t3_tick_found", cnt, 0, 3);
    cnt = 0;
    do begin step(); cnt++; end while (!ifb.tick && cnt < 8);
    check_rng("t3_tick_period", cnt, 4, 4);

    // dut_a: reset mid-count on bit 5
    ifa.sw_raw = 16'h8120;
    repeat (3) step();
    #3 rst = 1'b0;
    #1;
    check("t5_out_async", ifa.sw_out, 16'h0);
    check("t5_chg_async", ifa.sw_changed, 16'h0);
    check("t5_outb_async", ifb.sw_out, 16'h0);
    repeat (2) step();
    check("t5_tick_rst", {15'h0, ifa.tick}, 16'h0);
    check("t5_out_rst", ifa.sw_out | ifa.sw_rise | ifa.sw_fall, 16'h0);
    ifa.sw_raw = 16'h0020;
    ifb.sw_raw = 16'h0000;
    rst = 1'b1;
    first = -1; rises = 0; rise_acc = '0; fall_acc = '0;
    for (int e = 0; e < 12; e++) begin
      step();
      if (ifa.sw_out[5] && first < 0) first = e;
      if (ifa.sw_rise[5]) rises++;
      rise_acc |= ifa.sw_rise;
      fall_acc |= ifa.sw_fall | ifb.sw_rise | ifb.sw_fall;
    end
    check_rng("t5_accept_edge", first, 4, 4);
    check_rng("t5_rise_count", rises, 1, 1);
    check("t5_rise_bits", rise_acc, 16'h0020);
    check("t5_no_other_pulse", fall_acc, 16'h0);
    check("t5_out", ifa.sw_out, 16'h0020);
    check("t5_chg", ifa.sw_changed, 16'h0020);

    // dut_a: bounce bursts of at most 2 off-level cycles, then a stable level
    lvl_o = 16'h0020;
    for (int r = 0; r < 6; r++) begin
      lvl_t = 16'($urandom);
      rise_acc = '0; fall_acc = '0; bad = '0;
      for (int c = 0; c < 18; c++) begin
        noise = 16'($urandom);
        if (c >= 8)         ifa.sw_raw = lvl_t;
        else if (c % 3 == 2) ifa.sw_raw = lvl_o;
        else                ifa.sw_raw = noise;
        step();
        bad      |= (rise_acc & ifa.sw_rise) | (fall_acc & ifa.sw_fall) | (ifa.sw_rise & ifa.sw_fall);
        rise_acc |= ifa.sw_rise;
        fall_acc |= ifa.sw_fall;
      end
      check($sformatf("t6_r%0d_out", r),  ifa.sw_out, lvl_t);
      check($sformatf("t6_r%0d_rise", r), rise_acc, lvl_t & ~lvl_o);
      check($sformatf("t6_r%0d_fall", r), fall_acc, lvl_o & ~lvl_t);
      check($sformatf("t6_r%0d_dup", r),  bad, 16'h0);
      lvl_o = lvl_t;
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

endmodule
